// File: rtl/ibuf_multiport_if.sv
// Fetch/decode bundle for ibuf_multiport: slot-masked enqueue beat on the fetch
// side, oldest-first window plus retire count on the decode side.
interface ibuf_multiport_if #(
  parameter int IPF   = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 16,
  parameter int ILEN  = 32,
  parameter int XLEN  = 32
);
  logic                           fe_valid;
  logic                           fe_ready;
  logic [IPF-1:0]                 fe_slot_valid;
  logic [IPF*ILEN-1:0]            fe_instr;
  logic [IPF*XLEN-1:0]            fe_pc;
  logic [IPF*XLEN-1:0]            fe_pred_npc;
  logic [DW-1:0]                  de_valid;
  logic [DW*ILEN-1:0]             de_instr;
  logic [DW*XLEN-1:0]             de_pc;
  logic [DW*XLEN-1:0]             de_pred_npc;
  logic [$clog2(DW+1)-1:0]        de_accept;
  logic [$clog2(DEPTH+1)-1:0]     count;

  // master = fetch/decode environment, slave = the buffer
  modport master (
    output fe_valid, fe_slot_valid, fe_instr, fe_pc, fe_pred_npc, de_accept,
    input  fe_ready, de_valid, de_instr, de_pc, de_pred_npc, count
  );
  modport slave (
    input  fe_valid, fe_slot_valid, fe_instr, fe_pc, fe_pred_npc, de_accept,
    output fe_ready, de_valid, de_instr, de_pc, de_pred_npc, count
  );
endinterface

// File: rtl/ibuf_multiport.sv
// Multi-port circular instruction buffer between fetch and decode.
// Optional IBUF_PERF_CNT_EN adds full/empty cycle counters; IBUF_ASSERT_ON enables the over-accept check.
module ibuf_multiport #(
  parameter int INSTR_PER_FETCH = 4,
  parameter int DECODE_WIDTH    = 4,
  parameter int DEPTH           = 16,
  parameter int ILEN            = 32,
  parameter int XLEN            = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  ibuf_multiport_if.slave     bus
`ifdef IBUF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_full_cyc_o,
  output logic [31:0]         perf_empty_cyc_o
`endif
);
  localparam int IPF = INSTR_PER_FETCH;
  localparam int DW  = DECODE_WIDTH;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int EW  = $clog2(IPF + 1);

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_npc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [EW-1:0] slot_off [IPF+1];
  logic          enq_fire;
  logic [CW-1:0] n_enq;
  logic [CW-1:0] n_deq;

  // Ready looks only at registered occupancy: a full beat must always fit.
  assign bus.fe_ready = (count_reg <= CW'(DEPTH - IPF));
  assign enq_fire     = bus.fe_valid & bus.fe_ready;
  assign bus.count    = count_reg;

  // slot_off[k] = number of valid slots below k = compacted write offset of slot k
  assign slot_off[0] = '0;
  genvar gi;
  generate
    for (gi = 0; gi < IPF; gi++) begin : g_off
      assign slot_off[gi+1] = slot_off[gi] + EW'(bus.fe_slot_valid[gi]);
    end
  endgenerate

  assign n_enq = enq_fire ? CW'(slot_off[IPF]) : '0;

  always_comb begin
    n_deq = CW'(bus.de_accept);
    if (n_deq > count_reg) n_deq = count_reg;
    if (n_deq > CW'(DW))   n_deq = CW'(DW);
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      rd_ptr_next = rd_ptr_reg + AW'(n_deq);
      wr_ptr_next = wr_ptr_reg + AW'(n_enq);
      count_next  = count_reg + n_enq - n_deq;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset; only pointers define what is live.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < IPF; k++) begin
      if (enq_fire && !flush_i && !rst_i && bus.fe_slot_valid[k]) begin
        mem[wr_ptr_reg + AW'(slot_off[k])] <= {bus.fe_instr[k*ILEN +: ILEN],
                                               bus.fe_pc[k*XLEN +: XLEN],
                                               bus.fe_pred_npc[k*XLEN +: XLEN]};
      end
    end
  end

  generate
    for (gi = 0; gi < DW; gi++) begin : g_rd
      logic [AW-1:0] rd_idx;
      assign rd_idx                                = rd_ptr_reg + AW'(gi);
      assign bus.de_valid[gi]                      = (count_reg > CW'(gi));
      assign bus.de_instr[gi*ILEN +: ILEN]         = mem[rd_idx].instr;
      assign bus.de_pc[gi*XLEN +: XLEN]            = mem[rd_idx].pc;
      assign bus.de_pred_npc[gi*XLEN +: XLEN]      = mem[rd_idx].pred_npc;
    end
  endgenerate

`ifdef IBUF_ASSERT_ON
  // Retiring more than is present is a decode-side protocol error; the clamp above still protects state.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && count_reg != '0) begin
      assert (CW'(bus.de_accept) <= count_reg)
        else $error("ibuf_multiport: de_accept exceeds occupancy");
    end
  end
`endif

`ifdef IBUF_PERF_CNT_EN
  logic [31:0] perf_full_reg;
  logic [31:0] perf_empty_reg;

  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_full_reg  <= '0;
      perf_empty_reg <= '0;
    end else begin
      if (bus.fe_valid && !bus.fe_ready && perf_full_reg != 32'hFFFF_FFFF)
        perf_full_reg <= perf_full_reg + 32'd1;
      if (count_reg == '0 && perf_empty_reg != 32'hFFFF_FFFF)
        perf_empty_reg <= perf_empty_reg + 32'd1;
    end
  end

  assign perf_full_cyc_o  = perf_full_reg;
  assign perf_empty_cyc_o = perf_empty_reg;
`endif
endmodule
